// File: rtl/rapcores_wb_pkg.sv
// Shared register map and bit positions for the rapcores Wishbone command bridge.
package rapcores_wb_pkg;

    typedef enum logic [1:0] {
        REG_CMD    = 2'd0,
        REG_STATUS = 2'd1,
        REG_RSP    = 2'd2,
        REG_CTRL   = 2'd3
    } reg_e;

    localparam int ST_LEVEL_LSB = 0;
    localparam int ST_FULL      = 8;
    localparam int ST_EMPTY     = 9;
    localparam int ST_OVERFLOW  = 10;
    localparam int ST_RSP_PEND  = 11;

    localparam int CTRL_FLUSH   = 0;
    localparam int CTRL_CLR_OVF = 1;

endpackage

// File: rtl/rapcores_sync_fifo.sv
// First-word-fall-through synchronous FIFO; level-derived full/empty, flush beats pop.
module rapcores_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic [WIDTH-1:0]           rdata
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             pop_ok, push_ok;

    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign pop_ok  = pop & ~empty;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok = push & (~full | pop_ok);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)      level <= level + 1'b1;
            else if (pop_ok && !push_ok) level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/wb_cmd_bridge.sv
// Wishbone slave that queues 32-bit motion commands and exposes status, control and the
// motion core's last response word.
module wb_cmd_bridge
    import rapcores_wb_pkg::*;
#(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] ADDR_BASE = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] cmd_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    input  logic [31:0] rsp_data,
    input  logic        rsp_valid,
    output logic        irq
);
    localparam int AW = $clog2(DEPTH);

    logic          sel_hit, wr, rd;
    reg_e          reg_idx;
    logic          push, pop, flush, clr_ovf, drop;
    logic          full, empty;
    logic [AW:0]   level;
    logic          overflow, rsp_pending;
    logic [31:0]   rsp_reg;
    logic [31:0]   rd_word;
    logic          unused_adr;

    assign unused_adr = &{1'b0, wbs_adr_i[1:0]};

    // Suppressing on ack keeps a held strobe from being taken twice.
    assign sel_hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == ADDR_BASE[31:4]) & ~wbs_ack_o;
    assign reg_idx = reg_e'(wbs_adr_i[3:2]);
    assign wr      = sel_hit & wbs_we_i;
    assign rd      = sel_hit & ~wbs_we_i;

    assign push    = wr & (reg_idx == REG_CMD) & (wbs_sel_i == 4'hF);
    assign flush   = wr & (reg_idx == REG_CTRL) & wbs_sel_i[0] & wbs_dat_i[CTRL_FLUSH];
    assign clr_ovf = wr & (reg_idx == REG_CTRL) & wbs_sel_i[0] & wbs_dat_i[CTRL_CLR_OVF];
    assign pop     = cmd_valid & cmd_ready;
    assign drop    = push & full & ~pop;
    assign cmd_valid = ~empty;

    rapcores_sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (wbs_dat_i),
        .full  (full),
        .empty (empty),
        .level (level),
        .rdata (cmd_data)
    );

    always_comb begin
        rd_word = '0;
        case (reg_idx)
            REG_STATUS: begin
                rd_word[ST_LEVEL_LSB +: 8] = 8'(level);
                rd_word[ST_FULL]           = full;
                rd_word[ST_EMPTY]          = empty;
                rd_word[ST_OVERFLOW]       = overflow;
                rd_word[ST_RSP_PEND]       = rsp_pending;
            end
            REG_RSP: rd_word = rsp_reg;
            default: rd_word = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o   <= 1'b0;
            wbs_dat_o   <= '0;
            overflow    <= 1'b0;
            rsp_reg     <= '0;
            rsp_pending <= 1'b0;
            irq         <= 1'b0;
        end else begin
            wbs_ack_o <= sel_hit;
            wbs_dat_o <= rd ? rd_word : 32'h0;
            overflow  <= (overflow & ~clr_ovf) | drop;
            // A new response outranks the clear from a coincident RSP read.
            if (rsp_valid) begin
                rsp_reg     <= rsp_data;
                rsp_pending <= 1'b1;
            end else if (rd && reg_idx == REG_RSP) begin
                rsp_pending <= 1'b0;
            end
            irq <= rsp_pending | overflow;
        end
    end

endmodule

// File: tb/tb_wb_cmd_bridge.sv
// Directed bench for wb_cmd_bridge: bus handshake, FIFO ordering/overflow, response path, flush.
module tb_wb_cmd_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic [31:0] cmd_data;
    logic        cmd_valid, cmd_ready;
    logic [31:0] rsp_data;
    logic        rsp_valid;
    logic        irq;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] BASE    = 32'h3000_0000;
    localparam logic [31:0] A_CMD   = BASE + 32'h0;
    localparam logic [31:0] A_STAT  = BASE + 32'h4;
    localparam logic [31:0] A_RSP   = BASE + 32'h8;
    localparam logic [31:0] A_CTRL  = BASE + 32'hC;

    always #5 clk = ~clk;

    wb_cmd_bridge #(.DEPTH(8), .ADDR_BASE(BASE)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat),
        .cmd_data  (cmd_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .rsp_data  (rsp_data),
        .rsp_valid (rsp_valid),
        .irq       (irq)
    );

    // One access: strobe for one edge, capture ack/data #1 after it, then one idle cycle.
    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic got_ack, output logic [31:0] got_dat);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        @(posedge clk); #1;
        got_ack = ack;
        got_dat = rdat;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic a; logic [31:0] d;
        checks++; if (ack !== 1'b0 || cmd_valid !== 1'b0 || irq !== 1'b0 || rdat !== 32'h0) begin
            errors++; $display("FAIL reset_outputs: ack=%b cmd_valid=%b irq=%b dat=%h, want 0", ack, cmd_valid, irq, rdat);
        end
        bus(1'b0, A_STAT, 32'h0, 4'hF, a, d);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL reset_status_ack: got %b want 1", a); end
        checks++; if (d !== 32'h0000_0200) begin errors++; $display("FAIL reset_status: got %h want 00000200", d); end
        checks++; if (ack !== 1'b0 || rdat !== 32'h0) begin
            errors++; $display("FAIL ack_single_cycle: ack=%b dat=%h want 0/0", ack, rdat);
        end
    endtask

    task automatic test_single_push();
        logic a; logic [31:0] d;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_CMD; wdat = 32'hDEAD_BEEF; sel = 4'hF;
        @(posedge clk); #1;
        checks++; if (ack !== 1'b1 || cmd_valid !== 1'b1 || cmd_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL push_head: ack=%b valid=%b data=%h want 1/1/deadbeef", ack, cmd_valid, cmd_data);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        bus(1'b0, A_STAT, 32'h0, 4'hF, a, d);
        checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL push_level: got %h want 00000001", d); end
        cmd_ready = 1'b1; @(posedge clk); #1; cmd_ready = 1'b0;
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL single_pop: valid=%b want 0", cmd_valid); end
    endtask

    task automatic test_overflow_drain();
        logic a; logic [31:0] d;
        for (int i = 1; i <= 9; i++) bus(1'b1, A_CMD, i, 4'hF, a, d);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL overflow_push_ack: got %b want 1", a); end
        bus(1'b0, A_STAT, 32'h0, 4'hF, a, d);
        checks++; if (d !== 32'h0000_0508) begin errors++; $display("FAIL overflow_status: got %h want 00000508", d); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL overflow_irq: got %b want 1", irq); end
        cmd_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            checks++; if (cmd_valid !== 1'b1 || cmd_data !== i) begin
                errors++; $display("FAIL drain_word%0d: valid=%b data=%h want 1/%h", i, cmd_valid, cmd_data, i);
            end
            @(posedge clk); #1;
        end
        cmd_ready = 1'b0;
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: valid=%b want 0", cmd_valid); end
        bus(1'b1, A_CTRL, 32'h2, 4'h1, a, d);
        @(posedge clk); #1;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ovf_clear_irq: got %b want 0", irq); end
    endtask

    task automatic test_full_push_pop();
        logic a; logic [31:0] d;
        for (int i = 1; i <= 8; i++) bus(1'b1, A_CMD, 32'h100 + i, 4'hF, a, d);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_CMD; wdat = 32'hA; sel = 4'hF; cmd_ready = 1'b1;
        @(posedge clk); #1;
        cmd_ready = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL pushpop_ack: got %b want 1", ack); end
        @(posedge clk); #1;
        bus(1'b0, A_STAT, 32'h0, 4'hF, a, d);
        checks++; if (d !== 32'h0000_0108) begin errors++; $display("FAIL pushpop_status: got %h want 00000108", d); end
        cmd_ready = 1'b1;
        for (int i = 2; i <= 9; i++) begin
            logic [31:0] exp;
            exp = (i == 9) ? 32'hA : 32'h100 + i;
            checks++; if (cmd_valid !== 1'b1 || cmd_data !== exp) begin
                errors++; $display("FAIL pushpop_order%0d: valid=%b data=%h want 1/%h", i, cmd_valid, cmd_data, exp);
            end
            @(posedge clk); #1;
        end
        cmd_ready = 1'b0;
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL pushpop_empty: valid=%b want 0", cmd_valid); end
    endtask

    task automatic test_response();
        logic a; logic [31:0] d;
        rsp_data = 32'h1234_5678; rsp_valid = 1'b1;
        @(posedge clk); #1; rsp_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rsp_irq: got %b want 1", irq); end
        bus(1'b0, A_STAT, 32'h0, 4'hF, a, d);
        checks++; if (d !== 32'h0000_0A00) begin errors++; $display("FAIL rsp_status: got %h want 00000a00", d); end
        bus(1'b0, A_RSP, 32'h0, 4'hF, a, d);
        checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL rsp_read: got %h want 12345678", d); end
        bus(1'b0, A_STAT, 32'h0, 4'hF, a, d);
        checks++; if (d !== 32'h0000_0200) begin errors++; $display("FAIL rsp_cleared: got %h want 00000200", d); end
        // New response arriving on the same edge as an RSP read.
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_RSP; sel = 4'hF;
        rsp_data = 32'hCAFE_0001; rsp_valid = 1'b1;
        @(posedge clk); #1;
        rsp_valid = 1'b0; cyc = 1'b0; stb = 1'b0;
        checks++; if (rdat !== 32'h1234_5678) begin errors++; $display("FAIL rsp_race_old: got %h want 12345678", rdat); end
        @(posedge clk); #1;
        bus(1'b0, A_STAT, 32'h0, 4'hF, a, d);
        checks++; if (d !== 32'h0000_0A00) begin errors++; $display("FAIL rsp_race_pending: got %h want 00000a00", d); end
        bus(1'b0, A_RSP, 32'h0, 4'hF, a, d);
        checks++; if (d !== 32'hCAFE_0001) begin errors++; $display("FAIL rsp_race_new: got %h want cafe0001", d); end
    endtask

    task automatic test_flush_and_misc();
        logic a; logic [31:0] d;
        for (int i = 0; i < 3; i++) bus(1'b1, A_CMD, 32'h11 * (i + 1), 4'hF, a, d);
        bus(1'b0, A_STAT, 32'h0, 4'hF, a, d);
        checks++; if (d !== 32'h0000_0003) begin errors++; $display("FAIL flush_pre_level: got %h want 00000003", d); end
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_CTRL; wdat = 32'h3; sel = 4'hF;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", cmd_valid); end
        @(posedge clk); #1;
        bus(1'b0, A_STAT, 32'h0, 4'hF, a, d);
        checks++; if (d !== 32'h0000_0200) begin errors++; $display("FAIL flush_status: got %h want 00000200", d); end
        bus(1'b1, A_CMD, 32'h5555_AAAA, 4'h1, a, d);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL partial_ack: got %b want 1", a); end
        bus(1'b0, A_STAT, 32'h0, 4'hF, a, d);
        checks++; if (d !== 32'h0000_0200) begin errors++; $display("FAIL partial_ignored: got %h want 00000200", d); end
        bus(1'b1, A_CMD + 32'h10, 32'h77, 4'hF, a, d);
        checks++; if (a !== 1'b0 || cmd_valid !== 1'b0) begin
            errors++; $display("FAIL miss_addr: ack=%b valid=%b want 0/0", a, cmd_valid);
        end
        // Held strobe: acks land on every second cycle.
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_STAT; sel = 4'hF;
        @(posedge clk); #1; a = ack;
        @(posedge clk); #1;
        checks++; if (a !== 1'b1 || ack !== 1'b0) begin
            errors++; $display("FAIL held_stb_ack: first=%b second=%b want 1/0", a, ack);
        end
        @(posedge clk); #1;
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL held_stb_reack: got %b want 1", ack); end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; wdat = '0;
        cmd_ready = 1'b0; rsp_data = '0; rsp_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_single_push();
        test_overflow_drain();
        test_full_push_pop();
        test_response();
        test_flush_and_misc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
